// File: rtl/seg_load_ctrl.sv
// Segment-register / IP write sequencer: arbitrates interrupt, far-transfer and EU requests,
// strobes the register enables, flushes the prefetch queue after CS changes, tracks SS inhibit.
module seg_load_ctrl #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             if_flag,
  input  logic             int_req,
  input  logic [WIDTH-1:0] int_cs,
  input  logic [WIDTH-1:0] int_ip,
  input  logic             jmp_req,
  input  logic [WIDTH-1:0] jmp_cs,
  input  logic [WIDTH-1:0] jmp_ip,
  input  logic             mov_req,
  input  logic [1:0]       mov_sel,
  input  logic [WIDTH-1:0] mov_data,
  input  logic             instr_done,
  output logic [WIDTH-1:0] seg_d,
  output logic             ena_es,
  output logic             ena_cs,
  output logic             ena_ss,
  output logic             ena_ds,
  output logic [WIDTH-1:0] ip_d,
  output logic             ip_ena,
  output logic             flush,
  output logic             int_ack,
  output logic             jmp_ack,
  output logic             mov_ack,
  output logic             mov_err,
  output logic             busy,
  output logic             int_inhibit
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [1:0] WinInt = 2'd0;
  localparam logic [1:0] WinJmp = 2'd1;
  localparam logic [1:0] WinMov = 2'd2;

  localparam logic [1:0] SelEs = 2'd0;
  localparam logic [1:0] SelCs = 2'd1;
  localparam logic [1:0] SelSs = 2'd2;
  localparam logic [1:0] SelDs = 2'd3;

  localparam logic [1:0] FlushLast = 2'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic [1:0]       sel_q, sel_d;
  logic             err_q, err_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] seg_q, seg_d_d;
  logic [WIDTH-1:0] ip_q, ip_d_d;
  logic             inh_q, inh_d;
  logic             ena_es_q, ena_es_d;
  logic             ena_cs_q, ena_cs_d;
  logic             ena_ss_q, ena_ss_d;
  logic             ena_ds_q, ena_ds_d;
  logic             ip_ena_q, ip_ena_d;
  logic             flush_q, flush_d;
  logic             int_ack_q, int_ack_d;
  logic             jmp_ack_q, jmp_ack_d;
  logic             mov_ack_q, mov_ack_d;
  logic             mov_err_q, mov_err_d;
  logic             busy_q, busy_d;
  logic             int_ok;

  assign int_ok = int_req && if_flag && !inh_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    sel_d   = sel_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    seg_d_d = seg_q;
    ip_d_d  = ip_q;

    case (state_q)
      StIdle: begin
        if (int_ok) begin
          win_d   = WinInt;
          err_d   = 1'b0;
          seg_d_d = int_cs;
          ip_d_d  = int_ip;
          state_d = StWrite;
        end else if (jmp_req) begin
          win_d   = WinJmp;
          err_d   = 1'b0;
          seg_d_d = jmp_cs;
          ip_d_d  = jmp_ip;
          state_d = StWrite;
        end else if (mov_req) begin
          win_d = WinMov;
          sel_d = mov_sel;
          // CS may only change together with IP, so a lone CS write is refused
          if (mov_sel == SelCs) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            seg_d_d = mov_data;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (win_q == WinMov) begin
          state_d = StDone;
        end else begin
          cnt_d   = 2'd0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (cnt_q == FlushLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every strobe comes straight from a flop.
  always_comb begin
    ena_es_d  = (state_d == StWrite) && (win_d == WinMov) && (sel_d == SelEs);
    ena_ss_d  = (state_d == StWrite) && (win_d == WinMov) && (sel_d == SelSs);
    ena_ds_d  = (state_d == StWrite) && (win_d == WinMov) && (sel_d == SelDs);
    ena_cs_d  = (state_d == StWrite) && (win_d != WinMov);
    ip_ena_d  = (state_d == StWrite) && (win_d != WinMov);
    flush_d   = (state_d == StFlush);
    int_ack_d = (state_d == StDone) && (win_d == WinInt);
    jmp_ack_d = (state_d == StDone) && (win_d == WinJmp);
    mov_ack_d = (state_d == StDone) && (win_d == WinMov);
    mov_err_d = (state_d == StDone) && (win_d == WinMov) && err_d;
    busy_d    = (state_d != StIdle);

    // Setting on the SS write outranks a coincident instr_done
    inh_d = inh_q;
    if ((state_q == StWrite) && (win_q == WinMov) && (sel_q == SelSs)) begin
      inh_d = 1'b1;
    end else if (instr_done) begin
      inh_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      win_q     <= WinInt;
      sel_q     <= SelEs;
      err_q     <= 1'b0;
      cnt_q     <= 2'd0;
      seg_q     <= '0;
      ip_q      <= '0;
      inh_q     <= 1'b0;
      ena_es_q  <= 1'b0;
      ena_cs_q  <= 1'b0;
      ena_ss_q  <= 1'b0;
      ena_ds_q  <= 1'b0;
      ip_ena_q  <= 1'b0;
      flush_q   <= 1'b0;
      int_ack_q <= 1'b0;
      jmp_ack_q <= 1'b0;
      mov_ack_q <= 1'b0;
      mov_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d_d;
      ip_q      <= ip_d_d;
      inh_q     <= inh_d;
      ena_es_q  <= ena_es_d;
      ena_cs_q  <= ena_cs_d;
      ena_ss_q  <= ena_ss_d;
      ena_ds_q  <= ena_ds_d;
      ip_ena_q  <= ip_ena_d;
      flush_q   <= flush_d;
      int_ack_q <= int_ack_d;
      jmp_ack_q <= jmp_ack_d;
      mov_ack_q <= mov_ack_d;
      mov_err_q <= mov_err_d;
      busy_q    <= busy_d;
    end
  end

  assign seg_d       = seg_q;
  assign ip_d        = ip_q;
  assign ena_es      = ena_es_q;
  assign ena_cs      = ena_cs_q;
  assign ena_ss      = ena_ss_q;
  assign ena_ds      = ena_ds_q;
  assign ip_ena      = ip_ena_q;
  assign flush       = flush_q;
  assign int_ack     = int_ack_q;
  assign jmp_ack     = jmp_ack_q;
  assign mov_ack     = mov_ack_q;
  assign mov_err     = mov_err_q;
  assign busy        = busy_q;
  assign int_inhibit = inh_q;

endmodule

// File: tb/tb_seg_load_ctrl.sv
// Scoreboard bench for seg_load_ctrl: one instance with a 1-cycle flush, one with a 4-cycle flush.
module tb_seg_load_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, rst4, if_flag, int_req, jmp_req, jmp_req4, mov_req, instr_done;
  logic [15:0] int_cs, int_ip, jmp_cs, jmp_ip, mov_data;
  logic [1:0]  mov_sel;

  logic [15:0] seg_d, ip_d, seg_d4, ip_d4;
  logic ena_es, ena_cs, ena_ss, ena_ds, ip_ena, flush, int_ack, jmp_ack, mov_ack, mov_err;
  logic busy, int_inhibit;
  logic ena_es4, ena_cs4, ena_ss4, ena_ds4, ip_ena4, flush4, int_ack4, jmp_ack4, mov_ack4;
  logic mov_err4, busy4, int_inhibit4;

  seg_load_ctrl #(.WIDTH(16), .FLUSH_CYCLES(1)) dut (
    .CLK(CLK), .RST(RST), .if_flag(if_flag),
    .int_req(int_req), .int_cs(int_cs), .int_ip(int_ip),
    .jmp_req(jmp_req), .jmp_cs(jmp_cs), .jmp_ip(jmp_ip),
    .mov_req(mov_req), .mov_sel(mov_sel), .mov_data(mov_data), .instr_done(instr_done),
    .seg_d(seg_d), .ena_es(ena_es), .ena_cs(ena_cs), .ena_ss(ena_ss), .ena_ds(ena_ds),
    .ip_d(ip_d), .ip_ena(ip_ena), .flush(flush),
    .int_ack(int_ack), .jmp_ack(jmp_ack), .mov_ack(mov_ack), .mov_err(mov_err),
    .busy(busy), .int_inhibit(int_inhibit)
  );

  seg_load_ctrl #(.WIDTH(16), .FLUSH_CYCLES(4)) dut4 (
    .CLK(CLK), .RST(rst4), .if_flag(1'b0),
    .int_req(1'b0), .int_cs(int_cs), .int_ip(int_ip),
    .jmp_req(jmp_req4), .jmp_cs(jmp_cs), .jmp_ip(jmp_ip),
    .mov_req(1'b0), .mov_sel(mov_sel), .mov_data(mov_data), .instr_done(1'b0),
    .seg_d(seg_d4), .ena_es(ena_es4), .ena_cs(ena_cs4), .ena_ss(ena_ss4), .ena_ds(ena_ds4),
    .ip_d(ip_d4), .ip_ena(ip_ena4), .flush(flush4),
    .int_ack(int_ack4), .jmp_ack(jmp_ack4), .mov_ack(mov_ack4), .mov_err(mov_err4),
    .busy(busy4), .int_inhibit(int_inhibit4)
  );

  typedef struct packed {
    logic [9:0]  stb;
    logic        busy;
    logic        inh;
    logic [15:0] seg;
    logic [15:0] ip;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  localparam logic [9:0] StbEs = 10'h200;
  localparam logic [9:0] StbCs = 10'h100;
  localparam logic [9:0] StbSs = 10'h080;
  localparam logic [9:0] StbDs = 10'h040;
  localparam logic [9:0] StbIp = 10'h020;
  localparam logic [9:0] StbFl = 10'h010;
  localparam logic [9:0] StbIa = 10'h008;
  localparam logic [9:0] StbJa = 10'h004;
  localparam logic [9:0] StbMa = 10'h002;
  localparam logic [9:0] StbMe = 10'h001;

  obs_t obs0, obs1;
  assign obs0 = {ena_es, ena_cs, ena_ss, ena_ds, ip_ena, flush, int_ack, jmp_ack, mov_ack,
                 mov_err, busy, int_inhibit, seg_d, ip_d};
  assign obs1 = {ena_es4, ena_cs4, ena_ss4, ena_ds4, ip_ena4, flush4, int_ack4, jmp_ack4,
                 mov_ack4, mov_err4, busy4, int_inhibit4, seg_d4, ip_d4};

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name, input logic [63:0] exp);
    n_total++;
    $display("FAIL %s: expected event %h at cycle %0d never matched", name, exp, cyc);
  endtask

  task automatic push(input int which, input int c, input logic [9:0] stb, input logic b,
                      input logic inh, input logic [15:0] seg, input logic [15:0] ip);
    exp_t e;
    e.cyc = c;
    e.o   = {stb, b, inh, seg, ip};
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic scan(input int which, input obs_t o);
    exp_t e;
    bit   have;
    bit   stop;
    stop = 1'b0;
    while (!stop) begin
      have = (which == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        stop = 1'b1;
      end else begin
        e = (which == 0) ? q0[0] : q1[0];
        if (e.cyc >= cyc) begin
          stop = 1'b1;
        end else begin
          note_fail($sformatf("missed_evt%0d_c%0d", which, e.cyc), 64'(e.o));
          if (which == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
    if (o.stb != '0) begin
      have = (which == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (which == 0) ? q0[0] : q1[0];
      if (have && e.cyc == cyc) begin
        check($sformatf("evt%0d_c%0d", which, cyc), 64'(o), 64'(e.o));
        if (which == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end else begin
        check($sformatf("unexpected_evt%0d", which), 64'(o), 64'h0);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      scan(0, obs0);
      scan(1, obs1);
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  int g;

  initial begin
    RST = 1'b0; rst4 = 1'b0; if_flag = 1'b0; int_req = 1'b0; jmp_req = 1'b0;
    jmp_req4 = 1'b0; mov_req = 1'b0; instr_done = 1'b0;
    int_cs = '0; int_ip = '0; jmp_cs = '0; jmp_ip = '0; mov_data = '0; mov_sel = 2'd0;

    repeat (2) @(negedge CLK);
    RST = 1'b1; rst4 = 1'b1;
    check("reset_obs", 64'(obs0), 64'h0);
    check("reset_obs4", 64'(obs1), 64'h0);
    mon_en = 1'b1;
    repeat (10) @(negedge CLK);

    // Far jump
    jmp_cs = 16'h1234; jmp_ip = 16'h0100; jmp_req = 1'b1; g = cyc + 1;
    push(0, g,     StbCs | StbIp, 1'b1, 1'b0, 16'h1234, 16'h0100);
    push(0, g + 1, StbFl,         1'b1, 1'b0, 16'h1234, 16'h0100);
    push(0, g + 2, StbJa,         1'b1, 1'b0, 16'h1234, 16'h0100);
    wait_until(g + 2); jmp_req = 1'b0;
    wait_until(g + 3); check("jmp_idle_busy", 64'(busy), 64'h0);
    @(negedge CLK);

    // All three requesters at once
    if_flag = 1'b1; int_cs = 16'h0000; int_ip = 16'h0008; int_req = 1'b1;
    jmp_cs = 16'hABCD; jmp_ip = 16'h0200; jmp_req = 1'b1;
    mov_sel = 2'b11; mov_data = 16'h2000; mov_req = 1'b1; g = cyc + 1;
    push(0, g,     StbCs | StbIp, 1'b1, 1'b0, 16'h0000, 16'h0008);
    push(0, g + 1, StbFl,         1'b1, 1'b0, 16'h0000, 16'h0008);
    push(0, g + 2, StbIa,         1'b1, 1'b0, 16'h0000, 16'h0008);
    push(0, g + 4, StbCs | StbIp, 1'b1, 1'b0, 16'hABCD, 16'h0200);
    push(0, g + 5, StbFl,         1'b1, 1'b0, 16'hABCD, 16'h0200);
    push(0, g + 6, StbJa,         1'b1, 1'b0, 16'hABCD, 16'h0200);
    push(0, g + 8, StbDs,         1'b1, 1'b0, 16'h2000, 16'h0200);
    push(0, g + 9, StbMa,         1'b1, 1'b0, 16'h2000, 16'h0200);
    wait_until(g + 2); int_req = 1'b0;
    wait_until(g + 6); jmp_req = 1'b0;
    wait_until(g + 9); mov_req = 1'b0;
    wait_until(g + 11);

    // Lone CS write is refused: no enables, ack+err immediately
    mov_sel = 2'b01; mov_data = 16'hFFFF; mov_req = 1'b1; g = cyc + 1;
    push(0, g, StbMa | StbMe, 1'b1, 1'b0, 16'h2000, 16'h0200);
    wait_until(g); mov_req = 1'b0;
    wait_until(g + 2);

    // SS write sets the inhibit; a coincident instr_done does not clear it
    mov_sel = 2'b10; mov_data = 16'h3000; mov_req = 1'b1; g = cyc + 1;
    push(0, g,     StbSs, 1'b1, 1'b0, 16'h3000, 16'h0200);
    push(0, g + 1, StbMa, 1'b1, 1'b1, 16'h3000, 16'h0200);
    wait_until(g); instr_done = 1'b1;
    wait_until(g + 1);
    instr_done = 1'b0; mov_req = 1'b0;
    int_cs = 16'hF000; int_ip = 16'h0010; int_req = 1'b1;
    wait_until(g + 4);
    check("ss_inhibit_held", 64'(int_inhibit), 64'h1);
    check("ss_int_blocked", 64'(busy), 64'h0);
    wait_until(g + 5); instr_done = 1'b1;
    wait_until(g + 6); instr_done = 1'b0;
    push(0, g + 7, StbCs | StbIp, 1'b1, 1'b0, 16'hF000, 16'h0010);
    push(0, g + 8, StbFl,         1'b1, 1'b0, 16'hF000, 16'h0010);
    push(0, g + 9, StbIa,         1'b1, 1'b0, 16'hF000, 16'h0010);
    wait_until(g + 9); int_req = 1'b0;
    wait_until(g + 11);

    // Interrupts masked by IF are never granted
    if_flag = 1'b0; int_req = 1'b1; g = cyc;
    wait_until(g + 8);
    check("if0_no_grant", 64'(busy), 64'h0);
    int_req = 1'b0;
    @(negedge CLK);

    // Reset in the second of four flush cycles aborts the jump
    jmp_cs = 16'h5555; jmp_ip = 16'h6666; jmp_req4 = 1'b1; g = cyc + 1;
    push(1, g,     StbCs | StbIp, 1'b1, 1'b0, 16'h5555, 16'h6666);
    push(1, g + 1, StbFl,         1'b1, 1'b0, 16'h5555, 16'h6666);
    push(1, g + 2, StbFl,         1'b1, 1'b0, 16'h5555, 16'h6666);
    wait_until(g + 2); rst4 = 1'b0; jmp_req4 = 1'b0;
    wait_until(g + 3);
    check("abort_obs4", 64'(obs1), 64'h0);
    rst4 = 1'b1;
    wait_until(g + 12);

    mon_en = 1'b0;
    while (q0.size() > 0) begin
      note_fail($sformatf("pending_evt0_c%0d", q0[0].cyc), 64'(q0[0].o));
      void'(q0.pop_front());
    end
    while (q1.size() > 0) begin
      note_fail($sformatf("pending_evt1_c%0d", q1[0].cyc), 64'(q1[0].o));
      void'(q1.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
